// File: rtl/iram_pkg.sv
// Shared constants and FSM encoding for the iram boot loader and the iram itself.
package iram_pkg;

  localparam int unsigned IRAM_DEPTH = 8192;
  localparam logic [7:0]  FRAME_START = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN0    = 3'd1,
    S_LEN1    = 3'd2,
    S_DATA    = 3'd3,
    S_CSUM    = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

endpackage

// File: rtl/iram_loader.sv
// Boot-time iram loader: parses a framed byte stream, writes little-endian words
// to sequential iram word addresses and holds the core until a verified image lands.
module iram_loader
  import iram_pkg::*;
#(
  parameter int unsigned DEPTH          = IRAM_DEPTH,
  parameter int unsigned TIMEOUT        = 1_000_000,
  parameter int unsigned RELEASE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        iram_we,
  output logic [31:0] iram_waddr,
  output logic [31:0] iram_wdata,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned REL_W = $clog2(RELEASE_CYCLES + 1);

  state_t             r_state,    w_state_nxt;
  logic               r_rx_ready, w_rx_ready_nxt;
  logic               r_we,       w_we_nxt;
  logic [31:0]        r_waddr,    w_waddr_nxt;
  logic [31:0]        r_wdata,    w_wdata_nxt;
  logic               r_hold,     w_hold_nxt;
  logic               r_done,     w_done_nxt;
  logic               r_err,      w_err_nxt;
  logic [15:0]        r_count,    w_count_nxt;
  logic [1:0]         r_lane,     w_lane_nxt;
  logic [23:0]        r_buf,      w_buf_nxt;
  logic [7:0]         r_csum,     w_csum_nxt;
  logic [TMO_W-1:0]   r_tmo,      w_tmo_nxt;
  logic [REL_W-1:0]   r_rel,      w_rel_nxt;

  logic               w_xfer;
  logic               w_active;
  logic [15:0]        w_len;

  assign w_xfer   = rx_valid && r_rx_ready;
  assign w_active = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                    (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_len    = {rx_data, r_count[7:0]};

  // Next-state and next-register logic for the frame parser and write port.
  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = 1'b0;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    w_hold_nxt  = r_hold;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_count_nxt = r_count;
    w_lane_nxt  = r_lane;
    w_buf_nxt   = r_buf;
    w_csum_nxt  = r_csum;
    w_tmo_nxt   = r_tmo;
    w_rel_nxt   = r_rel;

    // Address advances once the write cycle has been presented.
    if (r_we) w_waddr_nxt = r_waddr + 32'd1;

    if (w_active) begin
      if (w_xfer)                       w_tmo_nxt = '0;
      else if (r_tmo != TMO_W'(TIMEOUT)) w_tmo_nxt = r_tmo + TMO_W'(1);
    end

    unique case (r_state)
      S_IDLE: begin
        if (w_xfer && (rx_data == FRAME_START)) begin
          w_state_nxt = S_LEN0;
          w_err_nxt   = 1'b0;
          w_hold_nxt  = 1'b1;
          w_waddr_nxt = '0;
          w_lane_nxt  = '0;
          w_csum_nxt  = '0;
          w_tmo_nxt   = '0;
        end
      end
      S_LEN0: begin
        if (w_xfer) begin
          w_count_nxt = {8'd0, rx_data};
          w_state_nxt = S_LEN1;
        end
      end
      S_LEN1: begin
        if (w_xfer) begin
          if ((w_len == 16'd0) || ({16'd0, w_len} > 32'(DEPTH))) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_count_nxt = w_len;
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_xfer) begin
          w_csum_nxt = r_csum + rx_data;
          w_lane_nxt = r_lane + 2'd1;
          unique case (r_lane)
            2'd0: w_buf_nxt[7:0]   = rx_data;
            2'd1: w_buf_nxt[15:8]  = rx_data;
            2'd2: w_buf_nxt[23:16] = rx_data;
            2'd3: begin
              w_we_nxt    = 1'b1;
              w_wdata_nxt = {rx_data, r_buf};
              if ((r_waddr + 32'd1) == {16'd0, r_count}) w_state_nxt = S_CSUM;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (w_xfer) begin
          if (rx_data == r_csum) begin
            w_state_nxt = S_RELEASE;
            w_rel_nxt   = '0;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_RELEASE: begin
        if (r_rel == REL_W'(RELEASE_CYCLES - 1)) begin
          w_state_nxt = S_IDLE;
          w_hold_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_rel_nxt = r_rel + REL_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Inter-byte gap expired: abort but keep the core held.
    if (w_active && !w_xfer && (r_tmo == TMO_W'(TIMEOUT))) begin
      w_state_nxt = S_IDLE;
      w_err_nxt   = 1'b1;
    end

    w_rx_ready_nxt = (w_state_nxt != S_RELEASE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rx_ready <= 1'b1;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_hold     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_count    <= '0;
      r_lane     <= '0;
      r_buf      <= '0;
      r_csum     <= '0;
      r_tmo      <= '0;
      r_rel      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rx_ready <= w_rx_ready_nxt;
      r_we       <= w_we_nxt;
      r_waddr    <= w_waddr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_hold     <= w_hold_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_count    <= w_count_nxt;
      r_lane     <= w_lane_nxt;
      r_buf      <= w_buf_nxt;
      r_csum     <= w_csum_nxt;
      r_tmo      <= w_tmo_nxt;
      r_rel      <= w_rel_nxt;
    end
  end

  assign rx_ready   = r_rx_ready;
  assign iram_we    = r_we;
  assign iram_waddr = r_waddr;
  assign iram_wdata = r_wdata;
  assign core_hold  = r_hold;
  assign load_done  = r_done;
  assign load_err   = r_err;

endmodule
